i2s_frame_ctrl: RTL and testbench

//  Master-mode I2S frame controller. Generates word-select from sclk_in, sequences sample capture from the
//  I2S receiver and sample load into the I2S transmitter. Moves each stereo frame to a DSP/effects stage

---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_ws_gen.sv | 55 +++++
 rtl/i2s_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S frame controller.
//   frame_state_t : frame sequencer states (IDLE, RUN)
//   DEF_WIDTH     : default bits per channel
//   stereo_t      : one stereo sample pair at the default width
//   cnt_w()       : width of the in-frame bit counter for a given channel width
package i2s_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] left;
    logic [DEF_WIDTH-1:0] right;
  } stereo_t;

  // A frame is 2*width sclk cycles; the counter must reach 2*width-1.
  function automatic int cnt_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/i2s_ws_gen.sv
// Word-select / bit-slot generator for the I2S frame controller.
// Owns the in-frame bit counter and the registered word-select.
// Ports:
//   sclk_i      in  : bit clock, rising edge
//   rst_i       in  : synchronous active-high reset
//   run_i       in  : sequencer is in RUN; counter held at 0 otherwise
//   ws_o        out : word-select, 0 for slots 0..WIDTH-1, 1 for WIDTH..2*WIDTH-1
//   cap_tick_o  out : strobe, RUN and slot == CAP_BIT (receiver capture point)
//   load_tick_o out : strobe, RUN and last slot of the frame (tx load / wrap point)
module i2s_ws_gen
  import i2s_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CAP_BIT = 2
) (
  input  logic sclk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic ws_o,
  output logic cap_tick_o,
  output logic load_tick_o
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAP_BIT);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ws_q, ws_d;

  // Outside RUN, and on the wrap slot, the counter returns to 0, so a
  // fresh frame always starts in the left half at slot 0.
  always_comb begin
    bit_cnt_d = '0;
    if (run_i && (bit_cnt_q != CNT_LAST)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    // ws is registered from the next count so it stays aligned with bit_cnt.
    ws_d = (bit_cnt_d >= CNT_HALF);
  end

  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      bit_cnt_q <= '0;
      ws_q      <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      ws_q      <= ws_d;
    end
  end

  assign ws_o        = ws_q;
  assign cap_tick_o  = run_i && (bit_cnt_q == CNT_CAP);
  assign load_tick_o = run_i && (bit_cnt_q == CNT_LAST);

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Master-mode I2S frame controller.
// Generates word-select, captures each stereo frame from the I2S receiver,
// hands it to the DSP stage (valid/ready), takes the processed frame back
// into a one-deep hold register and loads it into the I2S transmitter at
// the end of the frame so it goes out starting at the next frame's MSB slot.
// Optional feature: define I2S_UNDERRUN_CNT_EN to add underrun_cnt[15:0].
// Ports:
//   sclk_in                  in  : sole clock, rising edge
//   rst                      in  : synchronous active-high reset
//   en                       in  : run frames; when dropped the current frame completes
//   ws_gen                   out : word-select (0 left, 1 right)
//   rx_left/rx_right         in  : latest samples from the receiver
//   tx_left/tx_right         out : samples to the transmitter
//   dsp_in_l/r, dsp_in_valid out : captured frame towards DSP
//   dsp_in_ready             in  : DSP accepts captured frame
//   dsp_out_l/r, _valid      in  : processed frame from DSP
//   dsp_out_ready            out : hold register empty
//   clr_status               in  : clear sticky flags (and counter)
//   overrun / underrun       out : sticky error flags
//   underrun_cnt             out : saturating underrun event count (optional)
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CAP_BIT = 2
) (
  input  logic             sclk_in,
  input  logic             rst,
  input  logic             en,
  output logic             ws_gen,
  input  logic [WIDTH-1:0] rx_left,
  input  logic [WIDTH-1:0] rx_right,
  output logic [WIDTH-1:0] tx_left,
  output logic [WIDTH-1:0] tx_right,
  output logic [WIDTH-1:0] dsp_in_l,
  output logic [WIDTH-1:0] dsp_in_r,
  output logic             dsp_in_valid,
  input  logic             dsp_in_ready,
  input  logic [WIDTH-1:0] dsp_out_l,
  input  logic [WIDTH-1:0] dsp_out_r,
  input  logic             dsp_out_valid,
  output logic             dsp_out_ready,
  input  logic             clr_status,
  output logic             overrun,
  output logic             underrun
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  // ---------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------
  frame_state_t state_q, state_d;
  logic         run;
  logic         cap_tick;
  logic         load_tick;

  assign run = (state_q == RUN);

  i2s_ws_gen #(
    .WIDTH   (WIDTH),
    .CAP_BIT (CAP_BIT)
  ) u_ws_gen (
    .sclk_i      (sclk_in),
    .rst_i       (rst),
    .run_i       (run),
    .ws_o        (ws_gen),
    .cap_tick_o  (cap_tick),
    .load_tick_o (load_tick)
  );

  always_ff @(posedge sclk_in) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // load_tick is also the wrap slot: dropping en only takes effect there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (load_tick && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: capture, hold register, tx load, flags
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] in_l_q, in_l_d, in_r_q, in_r_d;
  logic             in_vld_q, in_vld_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic             ovr_q, ovr_d, und_q, und_d;

  logic in_hs, out_hs, ovr_set, und_set;

  assign in_hs   = in_vld_q && dsp_in_ready;
  assign out_hs  = dsp_out_valid && !hold_full_q;
  // A capture on top of an unconsumed frame loses it, unless the DSP
  // takes the old frame on the very same edge.
  assign ovr_set = cap_tick && in_vld_q && !dsp_in_ready;
  // Judged on the registered hold state: an accept in the load cycle
  // cannot feed this load.
  assign und_set = load_tick && !hold_full_q;

  always_comb begin
    in_l_d      = in_l_q;
    in_r_d      = in_r_q;
    in_vld_d    = in_vld_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    ovr_d       = ovr_q;
    und_d       = und_q;

    // DSP-in side; capture overrides a same-cycle handshake clear.
    if (in_hs) in_vld_d = 1'b0;
    if (cap_tick) begin
      in_l_d   = rx_left;
      in_r_d   = rx_right;
      in_vld_d = 1'b1;
    end

    // TX load drains the hold register; on an empty hold tx repeats.
    if (load_tick && hold_full_q) begin
      tx_l_d      = hold_l_q;
      tx_r_d      = hold_r_q;
      hold_full_d = 1'b0;
    end
    // out_hs requires an empty hold, so it never collides with the drain.
    if (out_hs) begin
      hold_l_d    = dsp_out_l;
      hold_r_d    = dsp_out_r;
      hold_full_d = 1'b1;
    end

    // Set wins over clear.
    if (clr_status) begin
      ovr_d = 1'b0;
      und_d = 1'b0;
    end
    if (ovr_set) ovr_d = 1'b1;
    if (und_set) und_d = 1'b1;
  end

  always_ff @(posedge sclk_in) begin
    if (rst) begin
      in_l_q      <= '0;
      in_r_q      <= '0;
      in_vld_q    <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      in_l_q      <= in_l_d;
      in_r_q      <= in_r_d;
      in_vld_q    <= in_vld_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
    end
  end

  assign dsp_in_l      = in_l_q;
  assign dsp_in_r      = in_r_q;
  assign dsp_in_valid  = in_vld_q;
  assign dsp_out_ready = !hold_full_q;
  assign tx_left       = tx_l_q;
  assign tx_right      = tx_r_q;
  assign overrun       = ovr_q;
  assign underrun      = und_q;

`ifdef I2S_UNDERRUN_CNT_EN
  // Saturating event counter; clear wins over increment.
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (clr_status)                          ucnt_d = '0;
    else if (und_set && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge sclk_in) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl (WIDTH=16, CAP_BIT=2).
// A frame-level vector table drives whole 32-slot frames; hand-written
// sequences cover same-cycle capture/handshake, accept during the load
// cycle, en drop mid-frame and reset mid-frame.
module tb_i2s_frame_ctrl;

  localparam int W = 16;

  logic         sclk_in = 1'b0;
  logic         rst, en;
  logic         ws_gen;
  logic [W-1:0] rx_left, rx_right, tx_left, tx_right;
  logic [W-1:0] dsp_in_l, dsp_in_r, dsp_out_l, dsp_out_r;
  logic         dsp_in_valid, dsp_in_ready, dsp_out_valid, dsp_out_ready;
  logic         clr_status, overrun, underrun;
  logic [15:0]  ucnt;

  // DSP model: echo mode returns each accepted input frame immediately;
  // otherwise the forced values are presented.
  logic         echo, force_vld;
  logic [W-1:0] force_l, force_r;

  assign dsp_out_valid = echo ? (dsp_in_valid & dsp_in_ready) : force_vld;
  assign dsp_out_l     = echo ? dsp_in_l : force_l;
  assign dsp_out_r     = echo ? dsp_in_r : force_r;

  i2s_frame_ctrl #(.WIDTH(W), .CAP_BIT(2)) dut (
    .sclk_in       (sclk_in),
    .rst           (rst),
    .en            (en),
    .ws_gen        (ws_gen),
    .rx_left       (rx_left),
    .rx_right      (rx_right),
    .tx_left       (tx_left),
    .tx_right      (tx_right),
    .dsp_in_l      (dsp_in_l),
    .dsp_in_r      (dsp_in_r),
    .dsp_in_valid  (dsp_in_valid),
    .dsp_in_ready  (dsp_in_ready),
    .dsp_out_l     (dsp_out_l),
    .dsp_out_r     (dsp_out_r),
    .dsp_out_valid (dsp_out_valid),
    .dsp_out_ready (dsp_out_ready),
    .clr_status    (clr_status),
    .overrun       (overrun),
    .underrun      (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    .underrun_cnt  (ucnt)
`endif
  );

`ifndef I2S_UNDERRUN_CNT_EN
  assign ucnt = 16'd0;
`endif

  always #5 sclk_in = ~sclk_in;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge sclk_in);
    #1;
  endtask

  // Run one frame from a slot-0 sample point to the next slot-0 sample point.
  task automatic run_frame(input bit chk_vld);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("ws_gen", {31'd0, ws_gen}, {31'd0, ((k % 32) >= 16)});
      if (chk_vld) chk("cap_slot", {31'd0, dsp_in_valid}, {31'd0, (k == 3)});
    end
  endtask

  typedef struct {
    logic [W-1:0] rx_l, rx_r;
    logic         rdy, ech, clr;
    logic [W-1:0] tx_l, tx_r;
    logic         ovr, und, ivld;
    logic [W-1:0] inl;
    logic [15:0]  cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'd0};
    tbl[1] = '{16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h1234, 16'd0};
    tbl[2] = '{16'hBEEF, 16'hCAFE, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'd1};
    tbl[3] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'd0};
    tbl[4] = '{16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 1'b1, 16'h1111, 16'd1};
    tbl[5] = '{16'h3333, 16'h4444, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b1, 16'h3333, 16'd2};
    tbl[6] = '{16'h5555, 16'h6666, 1'b1, 1'b1, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, 16'h5555, 16'd0};

    rst = 1'b1; en = 1'b0; rx_left = '0; rx_right = '0;
    dsp_in_ready = 1'b0; clr_status = 1'b0;
    echo = 1'b0; force_vld = 1'b0; force_l = '0; force_r = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ws", {31'd0, ws_gen}, 32'd0);
    chk("rst_tx_l", {16'd0, tx_left}, 32'd0);
    chk("rst_in_vld", {31'd0, dsp_in_valid}, 32'd0);
    chk("rst_out_rdy", {31'd0, dsp_out_ready}, 32'd1);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_und", {31'd0, underrun}, 32'd0);

    // Start: the next edge enters RUN with the counter at slot 0.
    rst = 1'b0; en = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      rx_left = tbl[i].rx_l; rx_right = tbl[i].rx_r;
      dsp_in_ready = tbl[i].rdy; echo = tbl[i].ech; clr_status = tbl[i].clr;
      run_frame(i == 0);
      chk($sformatf("v%0d_tx_l", i), {16'd0, tx_left}, {16'd0, tbl[i].tx_l});
      chk($sformatf("v%0d_tx_r", i), {16'd0, tx_right}, {16'd0, tbl[i].tx_r});
      chk($sformatf("v%0d_ovr", i), {31'd0, overrun}, {31'd0, tbl[i].ovr});
      chk($sformatf("v%0d_und", i), {31'd0, underrun}, {31'd0, tbl[i].und});
      chk($sformatf("v%0d_in_vld", i), {31'd0, dsp_in_valid}, {31'd0, tbl[i].ivld});
      chk($sformatf("v%0d_in_l", i), {16'd0, dsp_in_l}, {16'd0, tbl[i].inl});
`ifdef I2S_UNDERRUN_CNT_EN
      chk($sformatf("v%0d_ucnt", i), {16'd0, ucnt}, {16'd0, tbl[i].cnt});
`endif
    end

    // Same-cycle handshake and capture: new data wins, no overrun.
    clr_status = 1'b0; dsp_in_ready = 1'b0; echo = 1'b0;
    rx_left = 16'h7777; rx_right = 16'h8888;
    repeat (32) tick();                       // captured 7777, still valid
    rx_left = 16'h9999; rx_right = 16'hAAAA;
    repeat (2) tick();                        // slot 2
    dsp_in_ready = 1'b1;
    tick();
    chk("hs_cap_vld", {31'd0, dsp_in_valid}, 32'd1);
    chk("hs_cap_l", {16'd0, dsp_in_l}, 32'h9999);
    chk("hs_cap_r", {16'd0, dsp_in_r}, 32'hAAAA);
    chk("hs_cap_ovr", {31'd0, overrun}, 32'd0);
    tick();                                   // slot 4
    chk("hs_clr_vld", {31'd0, dsp_in_valid}, 32'd0);

    // Accept in the load cycle does not feed that load.
    clr_status = 1'b1;
    tick();                                   // slot 5
    clr_status = 1'b0;
    chk("clr_und", {31'd0, underrun}, 32'd0);
    repeat (26) tick();                       // slot 31
    force_vld = 1'b1; force_l = 16'hDEAD; force_r = 16'hBEEF;
    tick();                                   // slot 0
    force_vld = 1'b0;
    chk("ld_acc_und", {31'd0, underrun}, 32'd1);
    chk("ld_acc_tx_l", {16'd0, tx_left}, 32'h3333);
    chk("ld_acc_rdy", {31'd0, dsp_out_ready}, 32'd0);
    repeat (32) tick();
    chk("next_tx_l", {16'd0, tx_left}, 32'hDEAD);
    chk("next_tx_r", {16'd0, tx_right}, 32'hBEEF);
    chk("next_rdy", {31'd0, dsp_out_ready}, 32'd1);
`ifdef I2S_UNDERRUN_CNT_EN
    chk("ucnt_after", {16'd0, ucnt}, 32'd1);
`endif

    // en dropped at slot 5: frame completes, then IDLE.
    repeat (5) tick();
    en = 1'b0;
    repeat (26) tick();                       // slot 31
    chk("en_drop_ws31", {31'd0, ws_gen}, 32'd1);
    tick();
    chk("idle_ws", {31'd0, ws_gen}, 32'd0);
    rx_left = 16'h1357; rx_right = 16'h2468;
    repeat (5) tick();
    chk("idle_ws_hold", {31'd0, ws_gen}, 32'd0);
    chk("idle_no_cap", {16'd0, dsp_in_l}, 32'h9999);
    en = 1'b1; dsp_in_ready = 1'b0;
    tick();                                   // slot 0
    repeat (3) tick();                        // slot 3
    chk("restart_cap", {16'd0, dsp_in_l}, 32'h1357);
    repeat (12) tick();                       // slot 15
    chk("restart_ws15", {31'd0, ws_gen}, 32'd0);
    tick();                                   // slot 16
    chk("restart_ws16", {31'd0, ws_gen}, 32'd1);

    // Reset at slot 20 with a frame pending and the hold full.
    force_vld = 1'b1; force_l = 16'h0101; force_r = 16'h0202;
    repeat (4) tick();                        // slot 20
    force_vld = 1'b0;
    chk("pre_rst_vld", {31'd0, dsp_in_valid}, 32'd1);
    chk("pre_rst_rdy", {31'd0, dsp_out_ready}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_ws", {31'd0, ws_gen}, 32'd0);
    chk("mid_rst_tx_l", {16'd0, tx_left}, 32'd0);
    chk("mid_rst_tx_r", {16'd0, tx_right}, 32'd0);
    chk("mid_rst_in_l", {16'd0, dsp_in_l}, 32'd0);
    chk("mid_rst_in_r", {16'd0, dsp_in_r}, 32'd0);
    chk("mid_rst_vld", {31'd0, dsp_in_valid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, dsp_out_ready}, 32'd1);
    chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    chk("mid_rst_und", {31'd0, underrun}, 32'd0);
`ifdef I2S_UNDERRUN_CNT_EN
    chk("mid_rst_ucnt", {16'd0, ucnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
